axi_read_arbiter: RTL

- Shares one downstream AXI4 read port (AR and R channels) between two upstream masters.
- M0 is instruction fetch and M1 is data load; both sit between the CPU wrapper and the bus/slave side, which includes the default slave.
- Arbitration is round-robin and granted per transaction: a grant is held from AR acceptance through the RLAST handshake.
- Only one read burst is outstanding at a time.

---
 rtl/axi_read_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter: round-robin grant held from AR acceptance through
// the RLAST handshake, one burst outstanding, zero-latency R passthrough.
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0 (instruction fetch)
  input  logic [ID_W-1:0]   M0_ARID,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic [3:0]        M0_ARLEN,
  input  logic [2:0]        M0_ARSIZE,
  input  logic [1:0]        M0_ARBURST,
  input  logic              M0_ARVALID,
  output logic              M0_ARREADY,
  output logic [ID_W-1:0]   M0_RID,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic [1:0]        M0_RRESP,
  output logic              M0_RLAST,
  output logic              M0_RVALID,
  input  logic              M0_RREADY,
  // master 1 (data load)
  input  logic [ID_W-1:0]   M1_ARID,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [3:0]        M1_ARLEN,
  input  logic [2:0]        M1_ARSIZE,
  input  logic [1:0]        M1_ARBURST,
  input  logic              M1_ARVALID,
  output logic              M1_ARREADY,
  output logic [ID_W-1:0]   M1_RID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [1:0]        M1_RRESP,
  output logic              M1_RLAST,
  output logic              M1_RVALID,
  input  logic              M1_RREADY,
  // shared slave side
  output logic [ID_W:0]     S_ARID,
  output logic [ADDR_W-1:0] S_ARADDR,
  output logic [3:0]        S_ARLEN,
  output logic [2:0]        S_ARSIZE,
  output logic [1:0]        S_ARBURST,
  output logic              S_ARVALID,
  input  logic              S_ARREADY,
  input  logic [ID_W:0]     S_RID,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [1:0]        S_RRESP,
  input  logic              S_RLAST,
  input  logic              S_RVALID,
  output logic              S_RREADY
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;
  logic   prio, prio_nxt;

  logic g_arvalid, g_rready;
  assign g_arvalid = gnt ? M1_ARVALID : M0_ARVALID;
  assign g_rready  = gnt ? M1_RREADY  : M0_RREADY;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    prio_nxt  = prio;
    unique case (state)
      IDLE: begin
        if (M0_ARVALID || M1_ARVALID) begin
          state_nxt = ADDR;
          gnt_nxt   = (M0_ARVALID && M1_ARVALID) ? prio : M1_ARVALID;
        end
      end
      // grant stays put even if the winner drops ARVALID before acceptance
      ADDR: if (g_arvalid && S_ARREADY) state_nxt = DATA;
      DATA: begin
        if (S_RVALID && g_rready && S_RLAST) begin
          state_nxt = IDLE;
          prio_nxt  = ~gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    M0_RID     = '0;
    M0_RDATA   = '0;
    M0_RRESP   = '0;
    M0_RLAST   = 1'b0;
    M0_RVALID  = 1'b0;
    M1_RID     = '0;
    M1_RDATA   = '0;
    M1_RRESP   = '0;
    M1_RLAST   = 1'b0;
    M1_RVALID  = 1'b0;
    S_ARID     = '0;
    S_ARADDR   = '0;
    S_ARLEN    = '0;
    S_ARSIZE   = '0;
    S_ARBURST  = '0;
    S_ARVALID  = 1'b0;
    S_RREADY   = 1'b0;
    unique case (state)
      ADDR: begin
        S_ARID    = gnt ? {1'b1, M1_ARID} : {1'b0, M0_ARID};
        S_ARADDR  = gnt ? M1_ARADDR  : M0_ARADDR;
        S_ARLEN   = gnt ? M1_ARLEN   : M0_ARLEN;
        S_ARSIZE  = gnt ? M1_ARSIZE  : M0_ARSIZE;
        S_ARBURST = gnt ? M1_ARBURST : M0_ARBURST;
        S_ARVALID = g_arvalid;
        M0_ARREADY = !gnt && S_ARREADY;
        M1_ARREADY =  gnt && S_ARREADY;
      end
      // routing follows gnt; the master-index bit of S_RID is not consulted
      DATA: begin
        S_RREADY = g_rready;
        if (gnt) begin
          M1_RVALID = S_RVALID;
          M1_RID    = S_RID[ID_W-1:0];
          M1_RDATA  = S_RDATA;
          M1_RRESP  = S_RRESP;
          M1_RLAST  = S_RLAST;
        end else begin
          M0_RVALID = S_RVALID;
          M0_RID    = S_RID[ID_W-1:0];
          M0_RDATA  = S_RDATA;
          M0_RRESP  = S_RRESP;
          M0_RLAST  = S_RLAST;
        end
      end
      default: ;
    endcase
  end

endmodule
